nibble_neg_sequencer: RTL and testbench
=======================================

Name: nibble_neg_sequencer

Overview:
- Multi-cycle sequencer that computes the two's-complement negation of a WIDTH-bit operand, 4 bits per clock.
- Reuses one 4-bit invert-plus-carry cell, stepped from LSB nibble to MSB nibble, with the carry held in a register between steps.
- Sits beside the 4-bit complement datapath as its wide-word controller, for the signed arithmetic blocks that need negation wider than 4 bits.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 8.
- NIB, WIDTH/4, number of nibble steps (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0 or in the DONE cycle.
- din  input  WIDTH  operand; latched on the edge that accepts start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; dout and overflow are valid from this cycle on.
- dout  output  WIDTH  negated result; held until the next done.
- overflow  output  1  high when din was the most-negative value (1 followed by zeros); held with dout.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; busy=0, done=0, dout=0, overflow=0.
  - Internal operand, result, carry and step counter cleared.
  - Reset mid-RUN abandons the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch din, carry<=1, cnt<=0, go to RUN.
  - RUN: each edge processes nibble cnt, then cnt<=cnt+1. When cnt==NIB-1: write the final result to dout, set overflow, go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 -> accepted as a new operation (back-to-back), go to RUN.
    - Otherwise go to IDLE.
- Nibble step: n = operand[4*cnt+3 : 4*cnt].
  - res_nib = (~n + carry) mod 16.
  - carry_next = carry AND (n == 0).
  - Final carry-out is discarded.
- Latency:
  - The start-accept edge is E0; nibble steps occur on E1..E(NIB).
  - done is high in the cycle following E(NIB); for WIDTH=16, done is high after the 4th edge following E0.
  - Back-to-back throughput: one result every NIB+1 cycles.
- start handling:
  - start while busy=1 is ignored; not queued.
  - din is don't-care except on the accept edge.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Negation of 0 gives 0 with overflow=0.
  - overflow = operand[WIDTH-1] AND (operand[WIDTH-2:0] == 0).
- dout and overflow change only on the edge entering DONE, and otherwise hold their values.

Optional Feature:
- Macro SAT_NEG_EN.
- Defined: when overflow=1, dout is the most-positive value (0 followed by ones, e.g. 0x7FFF) instead of the wrapped value. overflow is still reported.
- Undefined: wrapped result, so 0x8000 -> 0x8000 with overflow=1.
- Latency is identical in both builds.

Decomposition:
- Package nibble_neg_pkg:
  - state enum {IDLE, RUN, DONE}.
  - NIB_W=4 constant.
  - Function computing the most-negative / most-positive constants from WIDTH.
- One sub-module, nibble_neg_cell (combinational):
  - Inputs: 4-bit n, carry_in.
  - Outputs: 4-bit res, carry_out.
  - Instantiated once and shared across all steps.

Test Plan:
- din=0x0001, start pulse -> done after 4 edges; dout=0xFFFF, overflow=0; busy high for 4 cycles.
- din=0x00F0 -> dout=0xFF10 (carry stops in nibble 1); din=0x0000 -> dout=0x0000, overflow=0.
- din=0x8000 -> overflow=1. dout=0x8000 without SAT_NEG_EN; dout=0x7FFF with SAT_NEG_EN.
- start=1 with din=0x1234 while busy -> ignored; the first result (din=0x0005 -> 0xFFFB) is unaffected. start held in the DONE cycle with din=0x0002 -> second done 5 cycles later, dout=0xFFFE.
- rst asserted at E2 of an operation -> busy, done, dout and overflow go to 0 immediately with no done pulse. A new start after release yields the correct result.

Source files
------------

// File: rtl/nibble_neg_pkg.sv
// Shared types and constants for the nibble-serial two's-complement negator.
package nibble_neg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;
    localparam int MAX_W = 64;

    // Callers truncate to their own WIDTH.
    function automatic logic [MAX_W-1:0] most_neg(input int width);
        return MAX_W'(1) << (width - 1);
    endfunction

    function automatic logic [MAX_W-1:0] most_pos(input int width);
        return most_neg(width) - MAX_W'(1);
    endfunction

endpackage

// File: rtl/nibble_neg_cell.sv
// One 4-bit invert-plus-carry step of a two's-complement negation.
module nibble_neg_cell
    import nibble_neg_pkg::*;
(
    input  logic [NIB_W-1:0] i_n,
    input  logic             i_carry,
    output logic [NIB_W-1:0] o_res,
    output logic             o_carry
);

    assign o_res   = ~i_n + {{(NIB_W-1){1'b0}}, i_carry};
    assign o_carry = i_carry & (i_n == '0);

endmodule

// File: rtl/nibble_neg_sequencer.sv
// Wide-word negation controller: steps one shared nibble cell LSB to MSB, 4 bits per clock.
// Optional build macro SAT_NEG_EN saturates the most-negative input to the most-positive value.
module nibble_neg_sequencer
    import nibble_neg_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / NIB_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             overflow,
    output state_e           o_dbg_state
);

    localparam int               CNT_W    = $clog2(NIB);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    state_e                   r_state;
    state_e                   w_next;
    logic                     w_accept;
    logic                     w_step;
    logic                     w_last;

    logic [WIDTH-1:0]         r_op;
    logic [WIDTH-NIB_W-1:0]   r_res;
    logic [WIDTH-1:0]         r_dout;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_carry;
    logic                     r_ovf_pend;
    logic                     r_ovf;

    logic [NIB_W-1:0]         w_res_nib;
    logic                     w_carry_out;
    logic [WIDTH-1:0]         w_final;
    logic [WIDTH-1:0]         w_dout_next;

    // The operand shifts right each step, so the cell always sees the current nibble at [3:0].
    nibble_neg_cell u_cell (
        .i_n     (r_op[NIB_W-1:0]),
        .i_carry (r_carry),
        .o_res   (w_res_nib),
        .o_carry (w_carry_out)
    );

    assign w_last  = (r_cnt == CNT_W'(NIB - 1));
    assign w_final = {w_res_nib, r_res};

`ifdef SAT_NEG_EN
    localparam logic [WIDTH-1:0] MOST_POS = WIDTH'(most_pos(WIDTH));
    assign w_dout_next = r_ovf_pend ? MOST_POS : w_final;
`else
    assign w_dout_next = w_final;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Completed nibbles enter r_res from the top; after NIB-1 steps nibble 0 sits at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_res      <= '0;
            r_dout     <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_op       <= din;
            r_carry    <= 1'b1;
            r_cnt      <= '0;
            r_ovf_pend <= (din == MOST_NEG);
        end else if (w_step) begin
            r_op    <= r_op >> NIB_W;
            r_res   <= (WIDTH-NIB_W)'(w_final >> NIB_W);
            r_carry <= w_carry_out;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_dout <= w_dout_next;
                r_ovf  <= r_ovf_pend;
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign dout        = r_dout;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nibble_neg_sequencer.sv
// Directed bench for nibble_neg_sequencer: driver tasks push expected {overflow, dout}; a monitor pops on done.
module tb_nibble_neg_sequencer;
    import nibble_neg_pkg::*;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         overflow;
    state_e       dbg_state;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   mon_e;
    logic [W-1:0] last_dout;
    logic         last_ovf;

    nibble_neg_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .din         (din),
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: results on done, and dout/overflow must hold between dones.
    always @(negedge clk) begin
        if (rst) begin
            last_dout = '0;
            last_ovf  = 1'b0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout", dout, mon_e[W-1:0]);
                check("overflow", overflow, mon_e[W]);
            end
            last_dout = dout;
            last_ovf  = overflow;
        end else begin
            check("dout_hold", dout, last_dout);
            check("ovf_hold", overflow, last_ovf);
        end
    end

    task automatic accept(input logic [W-1:0] d);
        @(posedge clk);
        #1;
        din   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = W'($urandom);
    endtask

    // Counts cycles with done low from the current point; bounded so a stuck DUT still reports.
    task automatic wait_done(input string name, input int exp_cycles);
        int n = 0;
        int nbusy = 0;
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            n++;
            nbusy += int'(busy);
        end
        check({name, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check({name, "_latency"}, n, exp_cycles);
            check({name, "_busy_cycles"}, nbusy, exp_cycles);
            check({name, "_busy_in_done"}, busy, 0);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] d, input logic [W-1:0] exp_d, input logic exp_o);
        exp_q.push_back({exp_o, exp_d});
        accept(d);
        wait_done(name, NIB);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;

        run_op("neg_0001", 16'h0001, 16'hFFFF, 1'b0);
        run_op("neg_00f0", 16'h00F0, 16'hFF10, 1'b0);
        run_op("neg_0000", 16'h0000, 16'h0000, 1'b0);
        run_op("neg_1234", 16'h1234, 16'hEDCC, 1'b0);
        run_op("neg_7fff", 16'h7FFF, 16'h8001, 1'b0);

        // start during RUN must be ignored, not queued.
        exp_q.push_back({1'b0, 16'hFFFB});
        accept(16'h0005);
        din   = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_ignore", NIB - 2);

        // start held in the DONE cycle is accepted back-to-back.
        din   = 16'h0002;
        start = 1'b1;
        exp_q.push_back({1'b0, 16'hFFFE});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("back_to_back", NIB);

`ifdef SAT_NEG_EN
        run_op("neg_8000", 16'h8000, 16'h7FFF, 1'b1);
`else
        run_op("neg_8000", 16'h8000, 16'h8000, 1'b1);
`endif

        // Reset two edges into an operation: outputs clear at once, no done follows.
        accept(16'h00F0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dout", dout, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_state", dbg_state, IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);

        run_op("after_rst", 16'h00F0, 16'hFF10, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
